// File: rtl/bp_me_mesh_router.sv
// Five-port mesh router: per-input FIFOs, dimension-ordered routing,
// round-robin output arbitration, and dropping/counting of U-turn flits.
module bp_me_mesh_router #(
  parameter width_p        = "inv",
  parameter x_cord_width_p = "inv",
  parameter y_cord_width_p = "inv",
  parameter fifo_els_p     = 2,
  parameter XY_order_p     = 1,
  localparam int dirs_lp   = 5
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [x_cord_width_p-1:0]    my_x_i,
  input  logic [y_cord_width_p-1:0]    my_y_i,
  input  logic [dirs_lp*width_p-1:0]   data_i,
  input  logic [dirs_lp-1:0]           v_i,
  output logic [dirs_lp-1:0]           ready_o,
  output logic [dirs_lp*width_p-1:0]   data_o,
  output logic [dirs_lp-1:0]           v_o,
  input  logic [dirs_lp-1:0]           ready_i,
  output logic                         route_err_o,
  output logic [7:0]                   err_cnt_o
);

  localparam int lg_els_lp = $clog2(fifo_els_p);
  localparam int ptr_w_lp  = lg_els_lp + 1;

  function automatic logic [2:0] wrap5(input logic [3:0] v);
    return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
  endfunction

  logic [width_p-1:0]  mem_q   [dirs_lp][fifo_els_p];
  logic [ptr_w_lp-1:0] wptr_q  [dirs_lp];
  logic [ptr_w_lp-1:0] wptr_d  [dirs_lp];
  logic [ptr_w_lp-1:0] rptr_q  [dirs_lp];
  logic [ptr_w_lp-1:0] rptr_d  [dirs_lp];
  logic [2:0]          rr_q    [dirs_lp];
  logic [2:0]          rr_d    [dirs_lp];
  logic [2:0]          lock_idx_q [dirs_lp];
  logic [2:0]          lock_idx_d [dirs_lp];
  logic [2:0]          grant_s [dirs_lp];
  logic [2:0]          route_s [dirs_lp];
  logic [width_p-1:0]  head_s  [dirs_lp];
  logic [dirs_lp-1:0]  req_s   [dirs_lp];
  logic [dirs_lp-1:0]  lock_q, lock_d;
  logic [dirs_lp-1:0]  empty_s, full_s, uturn_s, enq_s, deq_s, v_s;
  logic [dirs_lp-1:0]  x_gt_s, x_lt_s, y_gt_s, y_lt_s;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                route_err_q, route_err_d;
  logic [2:0]          cand_s, drops_s;
  logic                found_s;
  logic [8:0]          err_sum_s;

  // FIFO status, head flit and route decision per input
  always_comb begin
    for (int d = 0; d < dirs_lp; d++) begin
      empty_s[d] = (wptr_q[d] == rptr_q[d]);
      full_s[d]  = (wptr_q[d][lg_els_lp-1:0] == rptr_q[d][lg_els_lp-1:0])
                && (wptr_q[d][lg_els_lp] != rptr_q[d][lg_els_lp]);
      head_s[d]  = mem_q[d][rptr_q[d][lg_els_lp-1:0]];
      x_gt_s[d]  = head_s[d][x_cord_width_p-1:0] > my_x_i;
      x_lt_s[d]  = head_s[d][x_cord_width_p-1:0] < my_x_i;
      y_gt_s[d]  = head_s[d][x_cord_width_p+:y_cord_width_p] > my_y_i;
      y_lt_s[d]  = head_s[d][x_cord_width_p+:y_cord_width_p] < my_y_i;
      route_s[d] = 3'd0;
      if (XY_order_p != 0) begin
        if      (x_gt_s[d]) route_s[d] = 3'd2;
        else if (x_lt_s[d]) route_s[d] = 3'd1;
        else if (y_gt_s[d]) route_s[d] = 3'd4;
        else if (y_lt_s[d]) route_s[d] = 3'd3;
        else                route_s[d] = 3'd0;
      end else begin
        if      (y_gt_s[d]) route_s[d] = 3'd4;
        else if (y_lt_s[d]) route_s[d] = 3'd3;
        else if (x_gt_s[d]) route_s[d] = 3'd2;
        else if (x_lt_s[d]) route_s[d] = 3'd1;
        else                route_s[d] = 3'd0;
      end
      uturn_s[d] = !empty_s[d] && (d != 0) && (route_s[d] == 3'(d));
    end
  end

  // Output arbitration; a stalled output keeps its grant locked until it drains
  always_comb begin
    cand_s  = 3'd0;
    found_s = 1'b0;
    data_o  = '0;
    for (int o = 0; o < dirs_lp; o++) begin
      for (int i = 0; i < dirs_lp; i++) begin
        req_s[o][i] = !empty_s[i] && !uturn_s[i] && (route_s[i] == 3'(o));
      end
      v_s[o]     = |req_s[o];
      grant_s[o] = rr_q[o];
      found_s    = 1'b0;
      for (int k = 0; k < dirs_lp; k++) begin
        cand_s     = wrap5({1'b0, rr_q[o]} + 4'(k));
        grant_s[o] = (!found_s && req_s[o][cand_s]) ? cand_s : grant_s[o];
        found_s    = found_s | req_s[o][cand_s];
      end
      grant_s[o]    = lock_q[o] ? lock_idx_q[o] : grant_s[o];
      rr_d[o]       = (v_s[o] && ready_i[o]) ? wrap5({1'b0, grant_s[o]} + 4'd1) : rr_q[o];
      lock_d[o]     = v_s[o] && !ready_i[o];
      lock_idx_d[o] = grant_s[o];
      data_o[o*width_p +: width_p] = head_s[grant_s[o]];
    end
  end

  // Enqueue/dequeue pointer updates and drop accounting
  always_comb begin
    drops_s = 3'd0;
    for (int i = 0; i < dirs_lp; i++) begin
      deq_s[i] = uturn_s[i];
      for (int o = 0; o < dirs_lp; o++) begin
        deq_s[i] = deq_s[i] | (v_s[o] && ready_i[o] && (grant_s[o] == 3'(i)));
      end
      enq_s[i]  = v_i[i] && !full_s[i];
      wptr_d[i] = wptr_q[i] + ptr_w_lp'(enq_s[i]);
      rptr_d[i] = rptr_q[i] + ptr_w_lp'(deq_s[i]);
      drops_s   = drops_s + 3'(uturn_s[i]);
    end
    err_sum_s   = {1'b0, err_cnt_q} + 9'(drops_s);
    err_cnt_d   = err_sum_s[8] ? 8'hff : err_sum_s[7:0];
    route_err_d = |uturn_s;
  end

  // Flit storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk_i) begin
    for (int d = 0; d < dirs_lp; d++) begin
      if (enq_s[d]) mem_q[d][wptr_q[d][lg_els_lp-1:0]] <= data_i[d*width_p +: width_p];
    end
  end

  // Control state registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int d = 0; d < dirs_lp; d++) begin
        wptr_q[d]     <= '0;
        rptr_q[d]     <= '0;
        rr_q[d]       <= 3'd0;
        lock_idx_q[d] <= 3'd0;
      end
      lock_q      <= '0;
      err_cnt_q   <= 8'd0;
      route_err_q <= 1'b0;
    end else begin
      for (int d = 0; d < dirs_lp; d++) begin
        wptr_q[d]     <= wptr_d[d];
        rptr_q[d]     <= rptr_d[d];
        rr_q[d]       <= rr_d[d];
        lock_idx_q[d] <= lock_idx_d[d];
      end
      lock_q      <= lock_d;
      err_cnt_q   <= err_cnt_d;
      route_err_q <= route_err_d;
    end
  end

  assign ready_o     = ~full_s;
  assign v_o         = v_s & {dirs_lp{~reset_i}};
  assign route_err_o = route_err_q & ~reset_i;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_bp_me_mesh_router.sv
// Directed bench for bp_me_mesh_router: an X-first and a Y-first instance share stimulus.
module tb_bp_me_mesh_router;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [3:0]  my_x, my_y;
  logic [79:0] data_i;
  logic [4:0]  v_i, ready_i;
  logic [4:0]  ready_o, v_o, ready_o1, v_o1;
  logic [79:0] data_o, data_o1;
  logic        route_err_o, route_err_o1;
  logic [7:0]  err_cnt_o, err_cnt_o1;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  bp_me_mesh_router #(.width_p(16), .x_cord_width_p(4), .y_cord_width_p(4),
                      .fifo_els_p(2), .XY_order_p(1)) dut (
    .clk_i(clk), .reset_i(reset_i), .my_x_i(my_x), .my_y_i(my_y),
    .data_i(data_i), .v_i(v_i), .ready_o(ready_o), .data_o(data_o), .v_o(v_o),
    .ready_i(ready_i), .route_err_o(route_err_o), .err_cnt_o(err_cnt_o));

  bp_me_mesh_router #(.width_p(16), .x_cord_width_p(4), .y_cord_width_p(4),
                      .fifo_els_p(2), .XY_order_p(0)) dut_yx (
    .clk_i(clk), .reset_i(reset_i), .my_x_i(my_x), .my_y_i(my_y),
    .data_i(data_i), .v_i(v_i), .ready_o(ready_o1), .data_o(data_o1), .v_o(v_o1),
    .ready_i(ready_i), .route_err_o(route_err_o1), .err_cnt_o(err_cnt_o1));

  function automatic logic [15:0] flit(input logic [7:0] tag, input logic [3:0] y, input logic [3:0] x);
    return {tag, y, x};
  endfunction

  task automatic put(input int d, input logic [15:0] f);
    data_i[d*16 +: 16] = f;
  endtask

  task automatic test_reset;
    reset_i = 1'b1; v_i = 5'b0; ready_i = 5'h1f; data_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (v_o !== 5'b0 || route_err_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_hold v_o=%b route_err=%b expected 00000/0", v_o, route_err_o);
    end
    @(posedge clk); #1 reset_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (ready_o !== 5'h1f || ready_o1 !== 5'h1f) begin
      miscompares++; $display("FAIL reset_ready ready_o=%b/%b expected 11111", ready_o, ready_o1);
    end
    vectors++;
    if (v_o !== 5'b0 || route_err_o !== 1'b0 || err_cnt_o !== 8'd0) begin
      miscompares++; $display("FAIL reset_after v_o=%b err=%b cnt=%0d expected 00000/0/0", v_o, route_err_o, err_cnt_o);
    end
  endtask

  task automatic test_route(input logic [15:0] f, input int exp_xy, input int exp_yx);
    @(posedge clk); #1; put(0, f); v_i = 5'b00001;
    @(negedge clk);
    vectors++;
    if (v_o !== 5'b0) begin
      miscompares++; $display("FAIL route_latency flit=%h v_o=%b expected 00000", f, v_o);
    end
    @(posedge clk); #1; v_i = 5'b0;
    @(negedge clk);
    vectors++;
    if (v_o !== 5'(1 << exp_xy) || data_o[exp_xy*16 +: 16] !== f) begin
      miscompares++; $display("FAIL route_xy flit=%h v_o=%b data=%h expected %b/%h", f, v_o, data_o[exp_xy*16 +: 16], 5'(1 << exp_xy), f);
    end
    vectors++;
    if (v_o1 !== 5'(1 << exp_yx) || data_o1[exp_yx*16 +: 16] !== f) begin
      miscompares++; $display("FAIL route_yx flit=%h v_o=%b data=%h expected %b/%h", f, v_o1, data_o1[exp_yx*16 +: 16], 5'(1 << exp_yx), f);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (v_o !== 5'b0 || v_o1 !== 5'b0) begin
      miscompares++; $display("FAIL route_drain flit=%h v_o=%b/%b expected 00000", f, v_o, v_o1);
    end
  endtask

  task automatic test_round_robin;
    int sent[3];
    int got;
    logic [4:0]  rdy;
    logic [15:0] exp;
    got = 0;
    for (int s = 0; s < 3; s++) sent[s] = 0;
    ready_i = 5'b11110;
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) put(s + 1, flit({4'(s + 1), 4'd0}, 4'd1, 4'd1));
    v_i = 5'b01110;
    for (int cyc = 0; cyc < 60 && got < 12; cyc++) begin
      @(negedge clk);
      rdy = ready_o;
      if (v_o[0] && ready_i[0]) begin
        exp = flit({4'(got % 3 + 1), 4'(got / 3)}, 4'd1, 4'd1);
        vectors++;
        if (data_o[15:0] !== exp) begin
          miscompares++; $display("FAIL rr_order #%0d got %h expected %h", got, data_o[15:0], exp);
        end
        got++;
      end
      @(posedge clk); #1;
      for (int s = 0; s < 3; s++) begin
        if (v_i[s + 1] && rdy[s + 1]) begin
          sent[s]++;
          if (sent[s] == 4) v_i[s + 1] = 1'b0;
          else put(s + 1, flit({4'(s + 1), 4'(sent[s])}, 4'd1, 4'd1));
        end
      end
      if (cyc == 3) ready_i = 5'h1f;
    end
    v_i = 5'b0;
    vectors++;
    if (got != 12) begin
      miscompares++; $display("FAIL rr_count delivered %0d expected 12", got);
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] f[3];
    logic [4:0]  rdy;
    int got;
    for (int k = 0; k < 3; k++) f[k] = flit(8'hA0 + 8'(k), 4'd1, 4'd3);
    ready_i = 5'b11011;
    @(posedge clk); #1; put(0, f[0]); v_i = 5'b00001;
    @(posedge clk); #1; put(0, f[1]);
    @(posedge clk); #1; put(0, f[2]);
    @(negedge clk);
    vectors++;
    if (ready_o[0] !== 1'b0) begin
      miscompares++; $display("FAIL bp_full ready_o[P]=%b expected 0", ready_o[0]);
    end
    vectors++;
    if (v_o[2] !== 1'b1 || data_o[47:32] !== f[0]) begin
      miscompares++; $display("FAIL bp_hold v_o[E]=%b data=%h expected 1/%h", v_o[2], data_o[47:32], f[0]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (ready_o[0] !== 1'b0 || data_o[47:32] !== f[0]) begin
      miscompares++; $display("FAIL bp_stable ready_o[P]=%b data=%h expected 0/%h", ready_o[0], data_o[47:32], f[0]);
    end
    @(posedge clk); #1; ready_i = 5'h1f;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      @(negedge clk);
      rdy = ready_o;
      if (v_o[2]) begin
        vectors++;
        if (data_o[47:32] !== f[got]) begin
          miscompares++; $display("FAIL bp_order #%0d got %h expected %h", got, data_o[47:32], f[got]);
        end
        got++;
      end
      @(posedge clk); #1;
      if (v_i[0] && rdy[0]) v_i = 5'b0;
    end
    vectors++;
    if (got != 3) begin
      miscompares++; $display("FAIL bp_count delivered %0d expected 3", got);
    end
    @(negedge clk);
    vectors++;
    if (v_o !== 5'b0) begin
      miscompares++; $display("FAIL bp_drain v_o=%b expected 00000", v_o);
    end
  endtask

  task automatic test_uturn;
    int acc;
    logic [4:0] rdy;
    ready_i = 5'h1f;
    @(posedge clk); #1; put(2, flit(8'hE0, 4'd1, 4'd3)); v_i = 5'b00100;
    @(posedge clk); #1; v_i = 5'b0;
    @(negedge clk);
    vectors++;
    if (v_o !== 5'b0 || route_err_o !== 1'b0) begin
      miscompares++; $display("FAIL ut_noforward v_o=%b err=%b expected 00000/0", v_o, route_err_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (route_err_o !== 1'b1 || err_cnt_o !== 8'd1 || err_cnt_o1 !== 8'd1) begin
      miscompares++; $display("FAIL ut_drop err=%b cnt=%0d/%0d expected 1/1/1", route_err_o, err_cnt_o, err_cnt_o1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (route_err_o !== 1'b0 || err_cnt_o !== 8'd1 || v_o !== 5'b0) begin
      miscompares++; $display("FAIL ut_pulse err=%b cnt=%0d v_o=%b expected 0/1/00000", route_err_o, err_cnt_o, v_o);
    end
    acc = 0;
    v_i = 5'b00100;
    for (int cyc = 0; cyc < 1000 && acc < 299; cyc++) begin
      @(negedge clk);
      rdy = ready_o;
      @(posedge clk); #1;
      if (rdy[2]) acc++;
    end
    v_i = 5'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (acc != 299 || err_cnt_o !== 8'd255 || err_cnt_o1 !== 8'd255) begin
      miscompares++; $display("FAIL ut_saturate sent=%0d cnt=%0d/%0d expected 299/255/255", acc, err_cnt_o, err_cnt_o1);
    end
  endtask

  task automatic test_reset_mid;
    ready_i = 5'b11011;
    @(posedge clk); #1; put(0, flit(8'hB0, 4'd1, 4'd3)); v_i = 5'b00001;
    @(posedge clk); #1; put(0, flit(8'hB1, 4'd1, 4'd3));
    @(posedge clk); #1; v_i = 5'b0;
    @(negedge clk);
    vectors++;
    if (v_o[2] !== 1'b1 || ready_o[0] !== 1'b0) begin
      miscompares++; $display("FAIL rm_buffered v_o[E]=%b ready_o[P]=%b expected 1/0", v_o[2], ready_o[0]);
    end
    @(posedge clk); #1; reset_i = 1'b1;
    @(negedge clk);
    vectors++;
    if (v_o !== 5'b0 || v_o1 !== 5'b0) begin
      miscompares++; $display("FAIL rm_during v_o=%b/%b expected 00000", v_o, v_o1);
    end
    @(posedge clk); #1; reset_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (v_o !== 5'b0 || ready_o !== 5'h1f || err_cnt_o !== 8'd0 || route_err_o !== 1'b0) begin
      miscompares++; $display("FAIL rm_after v_o=%b ready=%b cnt=%0d err=%b expected 00000/11111/0/0", v_o, ready_o, err_cnt_o, route_err_o);
    end
    @(posedge clk); #1; ready_i = 5'h1f;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      vectors++;
      if (v_o !== 5'b0 || v_o1 !== 5'b0) begin
        miscompares++; $display("FAIL rm_empty cycle %0d v_o=%b/%b expected 00000", cyc, v_o, v_o1);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    my_x = 4'd1; my_y = 4'd1;
    test_reset;
    test_route(flit(8'h11, 4'd0, 4'd3), 2, 3);
    test_route(flit(8'h12, 4'd0, 4'd1), 3, 3);
    test_route(flit(8'h13, 4'd1, 4'd1), 0, 0);
    test_route(flit(8'h14, 4'd2, 4'd0), 1, 4);
    test_round_robin;
    test_backpressure;
    test_uturn;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
